// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate-decode stage.
//   imm_type_e   : immediate format classification (3-bit encoding)
//   OPC_*        : RV base opcodes recognised by the decoder
//   is_shift_f3  : funct3 values that select the shift-amount form of OP-IMM
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_I     = 3'd1,
    IMM_S     = 3'd2,
    IMM_B     = 3'd3,
    IMM_U     = 3'd4,
    IMM_J     = 3'd5,
    IMM_Z     = 3'd6,
    IMM_SHAMT = 3'd7
  } imm_type_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  // SLLI (001) and SRLI/SRAI (101) carry a shift amount instead of an I-immediate.
  function automatic logic is_shift_f3(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_decode_stage_if.sv
// Handshake bundle of the immediate-decode stage.
//   flush                          : discard all buffered entries
//   in_valid/in_ready/in_inst/in_pc: upstream (fetch) side
//   out_valid/out_ready/out_*      : downstream (register-read) side
// master = the environment around the stage, slave = the stage itself.
interface imm_decode_stage_if #(
  parameter int XLEN = 32
);
  import imm_pkg::*;

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  imm_type_e       out_imm_type;
  logic            out_illegal;

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_inst, out_pc, out_imm, out_imm_type, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_inst, out_pc, out_imm, out_imm_type, out_illegal
  );

endinterface

// File: rtl/imm_extract.sv
// Combinational immediate extractor.
//   inst     : 32-bit instruction word
//   imm      : sign- or zero-extended immediate, XLEN bits
//   imm_type : format classification
//   illegal  : unsupported opcode, or shift amount out of range for XLEN
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit EN_ZIMM = 1'b1
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output imm_type_e       imm_type,
  output logic            illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  // Sign extension relies on the width cast of a $signed operand.
  always_comb begin
    imm      = '0;
    imm_type = IMM_NONE;
    illegal  = 1'b0;
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        if ((opcode == OPC_OP_IMM) && is_shift_f3(funct3)) begin
          imm_type = IMM_SHAMT;
          if (XLEN == 64) begin
            imm = XLEN'(inst[25:20]);
          end else begin
            imm     = XLEN'(inst[24:20]);
            illegal = inst[25];
          end
        end else begin
          imm_type = IMM_I;
          imm      = XLEN'($signed(inst[31:20]));
        end
      end
      OPC_STORE: begin
        imm_type = IMM_S;
        imm      = XLEN'($signed({inst[31:25], inst[11:7]}));
      end
      OPC_BRANCH: begin
        imm_type = IMM_B;
        imm      = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_type = IMM_U;
        imm      = XLEN'($signed({inst[31:12], 12'b0}));
      end
      OPC_JAL: begin
        imm_type = IMM_J;
        imm      = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      end
      OPC_SYSTEM: begin
        // CSRRWI/CSRRSI/CSRRCI carry a 5-bit unsigned zimm in the rs1 field.
        if (EN_ZIMM && funct3[2]) begin
          imm_type = IMM_Z;
          imm      = XLEN'(inst[19:15]);
        end
      end
      OPC_OP, OPC_FENCE: begin
        imm_type = IMM_NONE;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode pipeline stage with a 2-entry skid buffer.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : imm_decode_stage_if.slave
//          in_*  : instruction + PC from fetch (valid/ready)
//          out_* : registered instruction, PC, immediate, type, illegal flag
//          flush : drops everything buffered and the input of that cycle
// in_ready is the inverse of the skid valid bit, so it is a flop output with
// no combinational path from out_ready.
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit EN_ZIMM = 1'b1
) (
  input logic               clk,
  input logic               rst,
  imm_decode_stage_if.slave bus
);

  if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
    $error("imm_decode_stage: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    imm_type_e       imm_type;
    logic            illegal;
  } dec_entry_t;

  logic [XLEN-1:0] ext_imm;
  imm_type_e       ext_type;
  logic            ext_illegal;
  dec_entry_t      dec_in;

  dec_entry_t main_q, main_d;
  dec_entry_t skid_q, skid_d;
  logic       main_vld_q, main_vld_d;
  logic       skid_vld_q, skid_vld_d;
  logic       accept;
  logic       consume;

  imm_extract #(
    .XLEN    (XLEN),
    .EN_ZIMM (EN_ZIMM)
  ) u_extract (
    .inst     (bus.in_inst),
    .imm      (ext_imm),
    .imm_type (ext_type),
    .illegal  (ext_illegal)
  );

  always_comb begin
    dec_in          = '0;
    dec_in.inst     = bus.in_inst;
    dec_in.pc       = bus.in_pc;
    dec_in.imm      = ext_imm;
    dec_in.imm_type = ext_type;
    dec_in.illegal  = ext_illegal;
  end

  assign accept  = bus.in_valid && !skid_vld_q;
  assign consume = main_vld_q && bus.out_ready;

  // accept and a valid skid entry are mutually exclusive, so the skid can
  // never be overwritten while it is being promoted to main.
  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (bus.flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (consume) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_d = dec_in;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      if (main_vld_q) begin
        skid_d     = dec_in;
        skid_vld_d = 1'b1;
      end else begin
        main_d     = dec_in;
        main_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign bus.in_ready     = !skid_vld_q;
  assign bus.out_valid    = main_vld_q;
  assign bus.out_inst     = main_q.inst;
  assign bus.out_pc       = main_q.pc;
  assign bus.out_imm      = main_q.imm;
  assign bus.out_imm_type = main_q.imm_type;
  assign bus.out_illegal  = main_q.illegal;

endmodule
